mas_alu_unit: RTL and testbench

//  Multi-cycle 4-operation ALU: add, subtract, logical left shift, right shift.

---
 rtl/mas_alu_unit_if.sv | 22 ++
 rtl/mas_alu_unit.sv | 167 ++++++++++++++++
 tb/tb_mas_alu_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mas_alu_unit_if.sv
// Request/result bus of the MAS ALU: level request with command and operands,
// registered result with a one-cycle ready strobe.
interface mas_alu_unit_if #(
  parameter int MAS_BLEN = 32
);
  logic                mas_alu_req;
  logic [1:0]          mas_alu_cmd;
  logic [MAS_BLEN-1:0] mas_alu_op1;
  logic [MAS_BLEN-1:0] mas_alu_op2;
  logic [MAS_BLEN-1:0] mas_alu_res;
  logic                mas_alu_ready;

  modport master (
    output mas_alu_req, mas_alu_cmd, mas_alu_op1, mas_alu_op2,
    input  mas_alu_res, mas_alu_ready
  );

  modport slave (
    input  mas_alu_req, mas_alu_cmd, mas_alu_op1, mas_alu_op2,
    output mas_alu_res, mas_alu_ready
  );
endinterface

// File: rtl/mas_alu_unit.sv
// MAS ALU: IDLE/OPER/DONE control FSM plus a registered add/sub/shift datapath.
// Define MAS_ALU_ASHR_EN to make cmd 11 an arithmetic right shift instead of logical.
package mas_alu_pkg;
  typedef enum logic [1:0] {
    CMD_ADD = 2'b00,
    CMD_SUB = 2'b01,
    CMD_SLL = 2'b10,
    CMD_SRL = 2'b11
  } type_mas_alu_cmd;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    DONE = 2'd2
  } mas_alu_fsm_state_e;
endpackage

module mas_alu_fsm
  import mas_alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  output mas_alu_fsm_state_e state_o,
  output logic               fsm_ready_o,
  output logic               fsm_oper_o
);
  mas_alu_fsm_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    fsm_ready_o = 1'b0;
    fsm_oper_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        fsm_ready_o = 1'b1;
        if (req_i) state_d = OPER;
      end
      OPER: begin
        fsm_oper_o = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        fsm_ready_o = 1'b1;
        state_d     = req_i ? OPER : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
endmodule

module mas_alu_dec
  import mas_alu_pkg::*;
#(
  parameter int MAS_BLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture_i,
  input  logic                oper_i,
  input  logic [1:0]          cmd_i,
  input  logic [MAS_BLEN-1:0] op1_i,
  input  logic [MAS_BLEN-1:0] op2_i,
  output logic [MAS_BLEN-1:0] res_o
);
  localparam int SHW = $clog2(MAS_BLEN);

  type_mas_alu_cmd     cmd_q, cmd_d;
  logic [MAS_BLEN-1:0] op1_q, op1_d;
  logic [MAS_BLEN-1:0] op2_q, op2_d;
  logic [MAS_BLEN-1:0] res_q, res_d;
  logic [SHW-1:0]      shamt;

  // Only the low SHW bits of op2 form the shift distance.
  assign shamt = op2_q[SHW-1:0];

  always_comb begin
    cmd_d = cmd_q;
    op1_d = op1_q;
    op2_d = op2_q;
    res_d = res_q;
    if (capture_i) begin
      cmd_d = type_mas_alu_cmd'(cmd_i);
      op1_d = op1_i;
      op2_d = op2_i;
    end
    if (oper_i) begin
      unique case (cmd_q)
        CMD_ADD: res_d = op1_q + op2_q;
        CMD_SUB: res_d = op1_q - op2_q;
        CMD_SLL: res_d = op1_q << shamt;
        CMD_SRL: begin
`ifdef MAS_ALU_ASHR_EN
          res_d = $signed(op1_q) >>> shamt;
`else
          res_d = op1_q >> shamt;
`endif
        end
        default: res_d = res_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= CMD_ADD;
      op1_q <= '0;
      op2_q <= '0;
      res_q <= '0;
    end else begin
      cmd_q <= cmd_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;
endmodule

module mas_alu_unit
  import mas_alu_pkg::*;
#(
  parameter int MAS_BLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  mas_alu_unit_if.slave  alu_if
);
  mas_alu_fsm_state_e mas_alu_fsm_state;
  logic               mas_alu_fsm_ready;
  logic               mas_alu_fsm_oper;

  mas_alu_fsm mfsm (
    .clk         (clk),
    .rst         (rst),
    .req_i       (alu_if.mas_alu_req),
    .state_o     (mas_alu_fsm_state),
    .fsm_ready_o (mas_alu_fsm_ready),
    .fsm_oper_o  (mas_alu_fsm_oper)
  );

  mas_alu_dec #(
    .MAS_BLEN (MAS_BLEN)
  ) mdec (
    .clk       (clk),
    .rst       (rst),
    .capture_i (mas_alu_fsm_ready & alu_if.mas_alu_req),
    .oper_i    (mas_alu_fsm_oper),
    .cmd_i     (alu_if.mas_alu_cmd),
    .op1_i     (alu_if.mas_alu_op1),
    .op2_i     (alu_if.mas_alu_op2),
    .res_o     (alu_if.mas_alu_res)
  );

  // DONE lasts exactly one cycle, so the registered state doubles as the ready strobe.
  assign alu_if.mas_alu_ready = (mas_alu_fsm_state == DONE);
endmodule

// File: tb/tb_mas_alu_unit.sv
// Self-checking bench for mas_alu_unit: directed corner cases, back-to-back traffic,
// mid-operation reset and randomized operations against an arithmetic reference model.
module tb_mas_alu_unit;
  localparam int BLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mas_alu_unit_if #(.MAS_BLEN(BLEN)) bus ();

  mas_alu_unit #(.MAS_BLEN(BLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .alu_if (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the command's meaning, shift distance taken modulo the width.
  function automatic logic [31:0] model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    logic [31:0] r;
    n = b % BLEN;
    r = a;
    case (c)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: r = a * (32'd1 << n);
      default: begin
        r = a / (32'd1 << n);
`ifdef MAS_ALU_ASHR_EN
        if (a[31]) for (int i = 0; i < n; i++) r[31-i] = 1'b1;
`endif
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic req, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.mas_alu_req = req;
    bus.mas_alu_cmd = c;
    bus.mas_alu_op1 = a;
    bus.mas_alu_op2 = b;
  endtask

  // Entered #1 after an edge with the FSM in IDLE; leaves it in IDLE, #1 after an edge.
  task automatic do_op(input string tag, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    exp = model(c, a, b);
    drive(1'b1, c, a, b);
    @(posedge clk); #1;
    drive(1'b0, 2'($urandom_range(3)), $urandom, $urandom);
    check({tag, "_busy_ready"}, 32'(bus.mas_alu_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_ready"}, 32'(bus.mas_alu_ready), 32'd1);
    check({tag, "_res"}, bus.mas_alu_res, exp);
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, 32'(bus.mas_alu_ready), 32'd0);
    check({tag, "_res_hold"}, bus.mas_alu_res, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  bc[$];
    logic [31:0] ba[$];
    logic [31:0] bb[$];
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] b;

    // Reset held for two edges with a live request.
    drive(1'b1, 2'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", bus.mas_alu_res, 32'd0);
    check("rst_ready", 32'(bus.mas_alu_ready), 32'd0);
    check("rst_state", 32'(dut.mas_alu_fsm_state), 32'd0);
    rst = 1'b0;

    do_op("add_wrap", 2'd0, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap_lit", bus.mas_alu_res, 32'd0);
    do_op("sub_borrow", 2'd1, 32'd5, 32'd7);
    check("sub_borrow_lit", bus.mas_alu_res, 32'hFFFF_FFFE);
    do_op("sub_plain", 2'd1, 32'd100, 32'd40);
    check("sub_plain_lit", bus.mas_alu_res, 32'd60);
    do_op("sll_31", 2'd2, 32'h0000_0001, 32'd31);
    check("sll_31_lit", bus.mas_alu_res, 32'h8000_0000);
    do_op("srl_33", 2'd3, 32'h8000_0000, 32'd33);
`ifdef MAS_ALU_ASHR_EN
    check("srl_33_lit", bus.mas_alu_res, 32'hC000_0000);
`else
    check("srl_33_lit", bus.mas_alu_res, 32'h4000_0000);
`endif
    do_op("sll_0", 2'd2, 32'hA5A5_0F0F, 32'd0);
    do_op("srl_0", 2'd3, 32'h8765_4321, 32'h0000_0020);
    do_op("sll_hi", 2'd2, 32'h0000_0003, 32'hFFFF_FFE1);

    // Mid-operation reset: op is dropped, no ready pulse.
    drive(1'b1, 2'd0, 32'd10, 32'd20);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mas_alu_req = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", 32'(bus.mas_alu_ready), 32'd0);
    check("midrst_state", 32'(dut.mas_alu_fsm_state), 32'd0);
    check("midrst_res", bus.mas_alu_res, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_after", 32'(bus.mas_alu_ready), 32'd0);

    // Back-to-back with req held: junk during OPER, next op during DONE.
    for (int i = 0; i < 24; i++) begin
      bc.push_back(2'($urandom_range(3)));
      ba.push_back(pick_operand());
      bb.push_back(pick_operand());
    end
    drive(1'b1, bc[0], ba[0], bb[0]);
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      #1;
      drive(1'b1, 2'($urandom_range(3)), $urandom, $urandom);
      @(posedge clk); #1;
      check("b2b_ready", 32'(bus.mas_alu_ready), 32'd1);
      check("b2b_res", bus.mas_alu_res, model(bc[i], ba[i], bb[i]));
      if (i < 23) drive(1'b1, bc[i+1], ba[i+1], bb[i+1]);
      else        bus.mas_alu_req = 1'b0;
      @(posedge clk);
    end
    #1;
    check("b2b_end_ready", 32'(bus.mas_alu_ready), 32'd0);
    check("b2b_end_state", 32'(dut.mas_alu_fsm_state), 32'd0);

    // Broad random.
    for (int i = 0; i < 1000; i++) begin
      c = 2'($urandom_range(3));
      a = pick_operand();
      b = pick_operand();
      do_op("rand", c, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
